// File: rtl/dmem_pkg.sv
// Shared definitions for the DLX data-memory responder.
// Contents: access-size encodings, responder FSM state type, and the big-endian
// byte-lane select helper used by the store path.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    // Byte-enable for an access; bit 3 is bits [31:24] (big-endian offset 0).
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b1000 >> offset;
            SZ_HALF: mask = offset[1] ? 4'b0011 : 4'b1100;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering for the data-memory responder (combinational).
// Ports:
//   size, offset     - normalised access size and byte offset within the word
//   is_unsigned      - zero-extend (1) or sign-extend (0) sub-word loads
//   wdata            - right-justified store data
//   rword            - word currently held in the addressed memory location
//   be               - byte enables for the store (bit 3 = bits [31:24])
//   wdata_sh         - store data replicated onto every lane; be selects
//   rdata_ext        - extracted and extended load data
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic [31:0] byte_shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign be = lane_mask(size, offset);

    // Replicating the datum onto all lanes avoids a shifter; be picks the live lane.
    always_comb begin
        case (size)
            SZ_BYTE: wdata_sh = {4{wdata[7:0]}};
            SZ_HALF: wdata_sh = {2{wdata[15:0]}};
            default: wdata_sh = wdata;
        endcase
    end

    // Offset 0 lives in the top byte, so shift right by (3 - offset) bytes.
    assign byte_shifted = rword >> {~offset, 3'b000};
    assign byte_sel     = byte_shifted[7:0];
    assign half_sel     = offset[1] ? rword[15:0] : rword[31:16];

    always_comb begin
        case (size)
            SZ_BYTE: rdata_ext = is_unsigned ? {24'd0, byte_sel}
                                             : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: rdata_ext = is_unsigned ? {16'd0, half_sel}
                                             : {{16{half_sel[15]}}, half_sel};
            default: rdata_ext = rword;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// DLX data-memory responder: accepts one load/store at a time over a valid/ready
// request channel, waits LATENCY cycles, then performs the access on a word-organised
// big-endian store and holds the response until the requester consumes it.
// Optional build macro: DMEM_ALIGN_CHECK_EN - flag misaligned/reserved-size accesses
// as errors (no write, zero data) instead of silently aligning them down.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   req_valid/req_ready           - request handshake
//   req_we, req_size, req_unsigned, req_addr, req_wdata - request fields
//   resp_valid/resp_ready         - response handshake
//   resp_rdata, resp_err          - load data (0 for stores) and error flag
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           accept, fire;

    logic           we_q;
    logic [1:0]     size_q;
    logic           uns_q;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;

    logic [31:0]    rdata_q;
    logic           err_q;

    logic [31:0]    mem [DEPTH];

    logic [AW-1:0]  idx;
    logic [1:0]     acc_size;
    logic [1:0]     acc_off;
    logic           acc_err;
    logic [3:0]     be;
    logic [31:0]    bmask;
    logic [31:0]    wdata_sh;
    logic [31:0]    rdata_ext;
    logic [31:0]    rword;

    // Address bits above the array span alias onto it.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW+2];

    assign idx   = addr_q[AW+1:2];
    assign rword = mem[idx];

`ifdef DMEM_ALIGN_CHECK_EN
    assign acc_err  = (size_q == SZ_HALF && addr_q[0]) ||
                      (size_q == SZ_WORD && addr_q[1:0] != 2'b00) ||
                      (size_q == 2'd3);
    assign acc_size = size_q;
    assign acc_off  = addr_q[1:0];
`else
    assign acc_err  = 1'b0;
    // Reserved size behaves as a word; offsets align down to the access size.
    assign acc_size = (size_q == 2'd3) ? SZ_WORD : size_q;
    always_comb begin
        case (acc_size)
            SZ_BYTE: acc_off = addr_q[1:0];
            SZ_HALF: acc_off = {addr_q[1], 1'b0};
            default: acc_off = 2'b00;
        endcase
    end
`endif

    dmem_lane_align u_lane_align (
        .size        (acc_size),
        .offset      (acc_off),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rword       (rword),
        .be          (be),
        .wdata_sh    (wdata_sh),
        .rdata_ext   (rdata_ext)
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bmask[8*i +: 8] = {8{be[i]}};
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    fire    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (fire) begin
                rdata_q <= (we_q || acc_err) ? 32'd0 : rdata_ext;
                err_q   <= acc_err;
            end
        end
    end

    // Request capture; contents are only meaningful while BUSY.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr[AW+1:0];
            wdata_q <= req_wdata;
        end
    end

    // Store commit; reset during BUSY suppresses it.
    always_ff @(posedge clk) begin
        if (!reset && fire && we_q && !acc_err) begin
            mem[idx] <= (rword & ~bmask) | (wdata_sh & bmask);
        end
    end

    assign req_ready  = (state_q == IDLE) && !reset;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
